// File: rtl/obi_result_mailbox.sv
// OBI responder through which X-HEEP software returns 32-bit result words to the host.
// Core pushes into a show-ahead FIFO over OBI; the host register block pops and reads status.
module obi_result_mailbox #(
    parameter int unsigned pDEPTH = 16,
    parameter int unsigned pCNT_W = 5
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    input  logic              pop_i,
    output logic [31:0]       rd_data_o,
    output logic              rd_valid_o,
    output logic [pCNT_W-1:0] count_o,
    output logic              full_o,
    output logic              done_o,
    input  logic              done_clr_i
);

    localparam int unsigned PtrW = $clog2(pDEPTH);

    typedef enum logic [1:0] {
        RegData   = 2'd0,
        RegStatus = 2'd1,
        RegCtrl   = 2'd2,
        RegNone   = 2'd3
    } reg_e;

    logic [31:0]       mem_q [pDEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [pCNT_W-1:0] count_q, count_d;
    logic              done_q, done_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;

    reg_e        reg_sel;
    logic        empty, full;
    logic        accept, push, pop, flush, set_done;
    logic [31:0] status;
    logic        unused;

    assign reg_sel = reg_e'(addr_i[3:2]);
    assign empty   = (count_q == '0);
    assign full    = (count_q == pCNT_W'(pDEPTH));

    // Only a DATA write into a full FIFO is held off; nothing is ever dropped.
    assign gnt_o   = req_i & ~(we_i & (reg_sel == RegData) & full);
    assign accept  = req_i & gnt_o;

    assign push     = accept & we_i & (reg_sel == RegData);
    assign flush    = accept & we_i & (reg_sel == RegCtrl) & wdata_i[0];
    assign set_done = accept & we_i & (reg_sel == RegCtrl) & wdata_i[1];
    assign pop      = pop_i & ~empty & ~flush;

    assign status = {7'b0, done_q, 6'b0, empty, full, 16'(count_q)};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + pCNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - pCNT_W'(1);
            end
        end
    end

    always_comb begin
        done_d = done_q;
        if (set_done) begin
            done_d = 1'b1;
        end else if (done_clr_i) begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = accept;
        rdata_d  = '0;
        if (accept && !we_i && reg_sel == RegStatus) begin
            rdata_d = status;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset: the count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign rd_valid_o = ~empty;
    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = full;
    assign done_o     = done_q;

    assign unused = ^{be_i, addr_i[31:4], addr_i[1:0]};

endmodule

// File: tb/tb_obi_result_mailbox.sv
// Directed and random bench for obi_result_mailbox, checked against a queue-based model
// that is stepped once per clock alongside the DUT.
module tb_obi_result_mailbox;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             req_i = 1'b0;
    logic             gnt_o;
    logic             we_i = 1'b0;
    logic [3:0]       be_i = 4'hf;
    logic [31:0]      addr_i = '0;
    logic [31:0]      wdata_i = '0;
    logic             rvalid_o;
    logic [31:0]      rdata_o;
    logic             pop_i = 1'b0;
    logic [31:0]      rd_data_o;
    logic             rd_valid_o;
    logic [CNT_W-1:0] count_o;
    logic             full_o;
    logic             done_o;
    logic             done_clr_i = 1'b0;

    always #5 clk = ~clk;

    obi_result_mailbox #(
        .pDEPTH (DEPTH),
        .pCNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .we_i       (we_i),
        .be_i       (be_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .pop_i      (pop_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .done_o     (done_o),
        .done_clr_i (done_clr_i)
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference model: word queue, sticky flag and the pending response.
    logic [31:0] m_q[$];
    logic        m_done = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    task automatic check(input string tag, input string fld, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, fld, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        int n;
        n = m_q.size();
        return {7'b0, m_done, 6'b0, (n == 0), (n == DEPTH), 16'(n)};
    endfunction

    // One clock: drive inputs, check the combinational grant, advance the model, check outputs.
    task automatic step(input string tag, input logic rst, input logic rq, input logic w,
                        input logic [1:0] a, input logic [31:0] wd, input logic p,
                        input logic c);
        logic [31:0] r;
        logic        exp_gnt, acc, fl, st, po;
        r          = $urandom();
        reset_i    = rst;
        req_i      = rq;
        we_i       = w;
        addr_i     = {r[31:4], a, r[1:0]};
        be_i       = r[7:4];
        wdata_i    = wd;
        pop_i      = p;
        done_clr_i = c;
        #1;
        exp_gnt = rq && !(w && a == 2'd0 && m_q.size() == DEPTH);
        check(tag, "gnt", {31'b0, gnt_o}, {31'b0, exp_gnt});
        acc = rq && exp_gnt;
        if (rst) begin
            m_q.delete();
            m_done   = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
        end else begin
            m_rvalid = acc;
            m_rdata  = (acc && !w && a == 2'd1) ? model_status() : 32'h0;
            fl = acc && w && a == 2'd2 && wd[0];
            st = acc && w && a == 2'd2 && wd[1];
            po = p && m_q.size() > 0 && !fl;
            if (fl) begin
                m_q.delete();
            end else begin
                if (po) void'(m_q.pop_front());
                if (acc && w && a == 2'd0) m_q.push_back(wd);
            end
            if (st) m_done = 1'b1;
            else if (c) m_done = 1'b0;
        end
        @(posedge clk);
        #1;
        check(tag, "rvalid", {31'b0, rvalid_o}, {31'b0, m_rvalid});
        if (m_rvalid || rst) check(tag, "rdata", rdata_o, m_rdata);
        check(tag, "count", 32'(count_o), 32'(m_q.size()));
        check(tag, "rd_valid", {31'b0, rd_valid_o}, {31'b0, m_q.size() != 0});
        check(tag, "full", {31'b0, full_o}, {31'b0, m_q.size() == DEPTH});
        check(tag, "done", {31'b0, done_o}, {31'b0, m_done});
        if (m_q.size() != 0) check(tag, "rd_data", rd_data_o, m_q[0]);
        else if (rst) check(tag, "rd_data", rd_data_o, 32'h0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [1:0] a, input logic [31:0] d,
                      input logic p);
        step(tag, 1'b0, 1'b1, 1'b1, a, d, p, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [1:0] a);
        step(tag, 1'b0, 1'b1, 1'b0, a, $urandom(), 1'b0, 1'b0);
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] wd;
        logic [1:0]  a;

        // Reset then idle
        step("reset", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        step("reset", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        idle("idle");
        check("idle", "count_const", 32'(count_o), 32'h0);

        // Two pushes, then drain in order
        wr("push2", 2'd0, 32'hDEADBEEF, 1'b0);
        wr("push2", 2'd0, 32'h12345678, 1'b0);
        check("push2", "head_const", rd_data_o, 32'hDEADBEEF);
        check("push2", "count_const", 32'(count_o), 32'd2);
        pop("pop2");
        check("pop2", "head_const", rd_data_o, 32'h12345678);
        pop("pop2");
        check("pop2", "count_const", 32'(count_o), 32'd0);
        pop("pop_empty");

        // Fill, stall the 17th write, release it with a pop
        for (int i = 0; i < DEPTH; i++) wr("fill", 2'd0, 32'hA000_0000 + 32'(i), 1'b0);
        check("fill", "full_const", {31'b0, full_o}, 32'd1);
        for (int i = 0; i < 3; i++) wr("stall", 2'd0, 32'hBEEF_0017, 1'b0);
        wr("stall_pop", 2'd0, 32'hBEEF_0017, 1'b1);
        wr("release", 2'd0, 32'hBEEF_0017, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop("drain17");
        idle("drained");

        // Simultaneous push and pop
        for (int i = 0; i < 3; i++) wr("pp_fill", 2'd0, $urandom(), 1'b0);
        wr("pp_mid", 2'd0, 32'hC0FFEE00, 1'b1);
        check("pp_mid", "count_const", 32'(count_o), 32'd3);
        for (int i = 0; i < 3; i++) pop("pp_drain");
        wr("pp_empty", 2'd0, 32'h5A5A5A5A, 1'b1);
        check("pp_empty", "count_const", 32'(count_o), 32'd1);

        // STATUS read with five words and done set
        for (int i = 0; i < 4; i++) wr("st_fill", 2'd0, $urandom(), 1'b0);
        wr("st_done", 2'd2, 32'h2, 1'b0);
        rd("st_read", 2'd1);
        check("st_read", "status_const", rdata_o, 32'h0100_0005);
        rd("rd_data", 2'd0);
        rd("rd_ctrl", 2'd2);
        rd("rd_none", 2'd3);
        wr("wr_status", 2'd1, 32'hFFFF_FFFF, 1'b0);
        wr("wr_none", 2'd3, 32'hFFFF_FFFF, 1'b0);

        // Flush against a pop; set done against a clear
        pop("to4");
        wr("flush_pop", 2'd2, 32'h1, 1'b1);
        check("flush_pop", "count_const", 32'(count_o), 32'd0);
        step("set_clr", 1'b0, 1'b1, 1'b1, 2'd2, 32'h2, 1'b0, 1'b1);
        check("set_clr", "done_const", {31'b0, done_o}, 32'd1);
        step("clr", 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);

        // Reset during an accepted transaction
        wr("pre_rst", 2'd0, 32'h1111_2222, 1'b0);
        step("rst_mid", 1'b1, 1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
        idle("post_rst");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            a  = 2'($urandom_range(0, 3));
            wd = $urandom();
            if (a == 2'd2) wd[0] = ($urandom_range(0, 7) == 0);
            step("rand", 1'b0, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7), a, wd,
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
